lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller sitting between the CPU's memory stage and the 1 KB byte-addressed, little-endian data memory. It turns byte, halfword and word load/store requests into word-aligned accesses on the memory's `addr/din/we/dout` port. Stores narrower than a word are done as read-modify-write, because the memory only writes whole 32-bit words. Loads return sign- or zero-extended data. Responses come back as a one-cycle pulse.

## Interface
- `ADDR_W`, default 10: memory address width (1 KB).
- `DATA_W`, default 32: data word width.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request strobe. Accepted when `req_ready` is 1.
- `req_ready`, out, 1: high only in IDLE.
- `req_op`, in, 3: operation code. LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=6, SH=7, SW=3.
- `req_addr`, in, 32: byte address. Bits above `ADDR_W` are ignored.
- `req_wdata`, in, 32: store data, right-justified.
- `rsp_valid`, out, 1: one-cycle completion pulse. There is no backpressure.
- `rsp_rdata`, out, 32: extended load data. It is 0 for stores and for errors.
- `rsp_err`, out, 1: misaligned access, qualified by `rsp_valid`.
- `mem_addr`, out, `ADDR_W`: word-aligned address. Bits [1:0] are always 0.
- `mem_din`, out, 32: memory write data.
- `mem_we`, out, 1: memory write enable.
- `mem_dout`, in, 32: combinational read data from the memory.

## Operation
- Request capture: on `req_valid && req_ready`, latch `req_op`, `req_addr` and `req_wdata`, then leave IDLE.
- Byte lane is `addr[1:0]`. Halfword lane is `{addr[1],1'b0}`.
- States and transitions:
  - IDLE to RD for loads, SB and SH.
  - IDLE to WR for SW.
  - IDLE to RESP for misaligned accesses.
  - RD to RESP for loads.
  - RD to WR for SB and SH.
  - WR to RESP.
  - RESP to IDLE.
- RD: drive `mem_addr`; register `mem_dout` into the word buffer at the clock edge.
- WR: `mem_we` = 1 for exactly one cycle.
  - SW: `mem_din` = `req_wdata`.
  - SB/SH: `mem_din` = buffer with the addressed lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
- Load extract:
  - LB/LH sign-extend the addressed byte or halfword.
  - LBU/LHU zero-extend it.
  - LW passes the word unchanged.
- Misaligned access: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0. No memory access is made; RESP gives `rsp_err`=1 and `rsp_rdata`=0.
- Undefined op code: treated as LW.
- A new request is never accepted while a response is pending. `req_valid` outside IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_din`=0, word buffer = 0.
- Accept edge = cycle 0. `rsp_valid` is asserted in the following cycle:
  - Load: cycle 2.
  - SW: cycle 2, with `mem_we` in cycle 1.
  - SB/SH: cycle 3, with RD in cycle 1 and `mem_we` in cycle 2.
  - Misaligned: cycle 1.
- Back-to-back: `req_ready` rises in the cycle after RESP. Peak throughput is one load every 3 cycles.
- `mem_addr`/`mem_din`/`mem_we` are registered outputs: glitch-free, stable for the whole WR cycle.
- Reset asserted mid-operation: immediate return to IDLE and `mem_we` drops at once. The pending response is discarded and no partial write occurs after reset is released.
- Wrap-around: word addresses are aligned, so a memory access never spans the 1 KB boundary. Address 0x3FC is the last word.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: misalignment detection as described above.
- `LSU_ALIGN_CHECK_EN` undefined:
  - `rsp_err` is tied to 0.
  - Low address bits below the access size are dropped: LH uses `addr[1]` only, LW ignores `addr[1:0]`.
  - The access proceeds normally.

## Structure
- Package `lsu_pkg`:
  - op code localparams;
  - FSM state encodings (IDLE, RD, WR, RESP);
  - width constants.
- Sub-module `lsu_lane_align`: purely combinational. It produces the load extract/extend and the store merge from (op, lane, word, wdata). The FSM, buffer and registered memory port stay in `lsu_ctrl`.

## Test plan
- Reset: hold `rst_n`=0 → `req_ready`=1, `rsp_valid`=0, `mem_we`=0, all data outputs 0.
- SW 0xDEADBEEF to 0x010 → `mem_we`=1 in cycle 1 with `mem_addr`=0x010 and `mem_din`=0xDEADBEEF; `rsp_valid` in cycle 2 with `rsp_rdata`=0.
- SB 0x000000AA to 0x012 after that store → RD cycle 1, then write 0xDEAABEEF in cycle 2, `rsp_valid` in cycle 3.
- Loads after that SB:
  - LB 0x013 → 0xFFFFFFDE.
  - LBU 0x013 → 0x000000DE.
  - LH 0x012 → 0xFFFFDEAA.
  - LHU 0x012 → 0x0000DEAA.
  - Each responds in cycle 2.
- LW 0x011:
  - With the macro: `rsp_valid` in cycle 1, `rsp_err`=1, `rsp_rdata`=0, no `mem_we`.
  - Without the macro: returns word 0x010 in cycle 2.
- Reset asserted during the RD cycle of SB 0x012 → no `mem_we` pulse and no `rsp_valid`; memory word unchanged; `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: op codes, FSM states, widths.
// Optional build macro used by lsu_ctrl: LSU_ALIGN_CHECK_EN.
package lsu_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;
  localparam logic [2:0] OP_SB  = 3'd6;
  localparam logic [2:0] OP_SH  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Sub-word stores need the old word first (read-modify-write).
  function automatic logic is_narrow_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] word,
  input  logic [15:0]       wdata_lo,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    if (op == OP_SB) begin
      case (lane)
        2'd0:    store_word = {word[31:8], wdata_lo[7:0]};
        2'd1:    store_word = {word[31:16], wdata_lo[7:0], word[7:0]};
        2'd2:    store_word = {word[31:24], wdata_lo[7:0], word[15:0]};
        default: store_word = {wdata_lo[7:0], word[23:0]};
      endcase
    end else if (op == OP_SH) begin
      store_word = lane[1] ? {wdata_lo, word[15:0]} : {word[31:16], wdata_lo};
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word requests onto a word-wide memory port.
// Build macro LSU_ALIGN_CHECK_EN enables misaligned-access error responses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [DATA_W-1:0] word_buf;
  logic [DATA_W-1:0] rd_word;
  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic              req_misaligned;
  logic              accept;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W];
  assign req_ready      = (state_q == ST_IDLE);
  assign accept         = req_valid && req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    req_misaligned = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
      OP_LB, OP_LBU, OP_SB: req_misaligned = 1'b0;
      default:              req_misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end
`else
  // Without the check, low bits below the access size are simply dropped.
  assign req_misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_misaligned)       state_d = ST_RESP;
          else if (req_op == OP_SW) state_d = ST_WR;
          else                      state_d = ST_RD;
        end
      end
      ST_RD:   state_d = is_narrow_store(op_q) ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Memory data is only sampled in RD; elsewhere the buffer keeps the align logic quiet.
  assign rd_word = (state_q == ST_RD) ? mem_dout : word_buf;

  lsu_lane_align u_lane_align (
    .op         (op_q),
    .lane       (lane_q),
    .word       (rd_word),
    .wdata_lo   (wdata_q[15:0]),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // NOTE: the word buffer is a single register, not a memory array, so it is reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_LB;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
      word_buf  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_misaligned) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_op == OP_SW) begin
                mem_din <= req_wdata;
                mem_we  <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          word_buf <= mem_dout;
          if (is_narrow_store(op_q)) begin
            mem_din <= store_word;
            mem_we  <= 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        ST_WR: begin
          mem_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a behavioural 1 KB word memory.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  logic [31:0] mem [256];

  lsu_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_din;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Observations from the most recent request, cycles counted from the accept edge.
  int          rsp_cyc, we_cyc, rsp_cnt, we_cnt;
  logic [31:0] rsp_data, we_din, we_addr;
  logic        rsp_e, ready_c1;

  task automatic observe(input int n_cycles);
    for (int k = 1; k <= n_cycles; k++) begin
      @(negedge clk);
      if (k == 1) ready_c1 = req_ready;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc == 0) begin
          rsp_cyc  = k;
          rsp_data = rsp_rdata;
          rsp_e    = rsp_err;
        end
      end
      if (mem_we) begin
        we_cnt++;
        if (we_cyc == 0) begin
          we_cyc  = k;
          we_din  = mem_din;
          we_addr = {22'd0, mem_addr};
        end
      end
    end
  endtask

  task automatic clear_obs();
    rsp_cyc = 0; we_cyc = 0; rsp_cnt = 0; we_cnt = 0;
    rsp_data = '0; we_din = '0; we_addr = '0; rsp_e = 1'b0; ready_c1 = 1'b1;
  endtask

  // Issue one request and watch a bounded window of 6 cycles.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    clear_obs();
    check({tag, " ready_before"}, {31'd0, req_ready}, 32'd1);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    observe(6);
    check({tag, " ready_c1"}, {31'd0, ready_c1}, 32'd0);
    check({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic expect_rsp(input string tag, input int exp_rsp_cyc, input int exp_we_cyc,
                            input logic [31:0] exp_rdata, input logic exp_err);
    check({tag, " rsp_cycle"}, rsp_cyc, exp_rsp_cyc);
    check({tag, " rsp_pulses"}, rsp_cnt, 1);
    check({tag, " rsp_rdata"}, rsp_data, exp_rdata);
    check({tag, " rsp_err"}, {31'd0, rsp_e}, {31'd0, exp_err});
    check({tag, " we_cycle"}, we_cyc, exp_we_cyc);
    check({tag, " we_pulses"}, we_cnt, (exp_we_cyc == 0) ? 0 : 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    // Reset state
    #12;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("reset mem_we",    {31'd0, mem_we}, 32'd0);
    check("reset mem_addr",  {22'd0, mem_addr}, 32'd0);
    check("reset mem_din",   mem_din, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SW then SB read-modify-write
    issue("sw", OP_SW, 32'h010, 32'hDEADBEEF);
    expect_rsp("sw", 2, 1, 32'd0, 1'b0);
    check("sw mem_addr", we_addr, 32'h010);
    check("sw mem_din",  we_din, 32'hDEADBEEF);

    issue("sb", OP_SB, 32'h012, 32'h000000AA);
    expect_rsp("sb", 3, 2, 32'd0, 1'b0);
    check("sb mem_addr", we_addr, 32'h010);
    check("sb mem_din",  we_din, 32'hDEAABEEF);

    // Loads of the merged word
    issue("lb", OP_LB, 32'h013, 32'd0);
    expect_rsp("lb", 2, 0, 32'hFFFFFFDE, 1'b0);
    issue("lbu", OP_LBU, 32'h013, 32'd0);
    expect_rsp("lbu", 2, 0, 32'h000000DE, 1'b0);
    issue("lh", OP_LH, 32'h012, 32'd0);
    expect_rsp("lh", 2, 0, 32'hFFFFDEAA, 1'b0);
    issue("lhu", OP_LHU, 32'h012, 32'd0);
    expect_rsp("lhu", 2, 0, 32'h0000DEAA, 1'b0);
    issue("lw", OP_LW, 32'h010, 32'd0);
    expect_rsp("lw", 2, 0, 32'hDEAABEEF, 1'b0);

    // Last word of memory, upper halfword, high address bits ignored
    issue("sh_top", OP_SH, 32'hFFFF_F3FE, 32'hCAFE1234);
    expect_rsp("sh_top", 3, 2, 32'd0, 1'b0);
    check("sh_top mem_addr", we_addr, 32'h3FC);
    check("sh_top mem_din",  we_din, 32'h12340000);
    issue("lh_top", OP_LH, 32'h3FE, 32'd0);
    expect_rsp("lh_top", 2, 0, 32'h00001234, 1'b0);
    issue("lb_top", OP_LB, 32'h3FF, 32'd0);
    expect_rsp("lb_top", 2, 0, 32'h00000012, 1'b0);

    // Misaligned word load
`ifdef LSU_ALIGN_CHECK_EN
    issue("lw_mis", OP_LW, 32'h011, 32'd0);
    expect_rsp("lw_mis", 1, 0, 32'd0, 1'b1);
`else
    issue("lw_mis", OP_LW, 32'h011, 32'd0);
    expect_rsp("lw_mis", 2, 0, 32'hDEAABEEF, 1'b0);
`endif

    // Reset during the RD cycle of an SB
    clear_obs();
    req_op = OP_SB; req_addr = 32'h012; req_wdata = 32'h00000055; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
    observe(2);
    rst_n = 1'b1;
    observe(4);
    check("rst_mid we_pulses", we_cnt, 0);
    check("rst_mid rsp_pulses", rsp_cnt, 0);
    check("rst_mid mem_word", mem[8'h04], 32'hDEAABEEF);
    check("rst_mid ready", {31'd0, req_ready}, 32'd1);

    issue("lw_post", OP_LW, 32'h010, 32'd0);
    expect_rsp("lw_post", 2, 0, 32'hDEAABEEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
